// File: rtl/mainfsm_ws.sv
// -----------------------------------------------------------------------------
// mainfsm_ws
//
// Multicycle main control FSM for the ARM-subset datapath. It sequences
// fetch, decode, execute, memory and writeback, and drives the datapath mux
// selects and write enables. Compared with a fixed-latency main FSM it adds
// a memory wait-state handshake, an optional FPU execute path with a
// start/done handshake, a per-visit timeout on every wait state, and a
// sticky fault report.
//
// Parameters
//   FPU_EN    1: Op=11 runs the FPU path; 0: Op=11 faults as undefined.
//   WAIT_MAX  maximum cycles a wait state may last (0 disables the timeout).
//   WAIT_W    wait counter width; 2**WAIT_W must exceed WAIT_MAX.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   Op[1:0]              instruction class: 00 dp, 01 mem, 10 branch, 11 FPU
//   Funct[5:0]           [5] immediate operand, [0] load(1)/store(0)
//   MemReady             memory completes the current access this cycle
//   FPUDone              FPU result valid this cycle
//   IRWrite .. ALUOp     1-bit datapath controls
//   ALUSrcA/B, ResultSrc 2-bit datapath mux selects
//   MemReq               memory access request
//   FPUStart             one-cycle FPU launch pulse per FPUEX visit
//   FPUW                 FPU register write enable
//   Fault, FaultCause    sticky fault flag and cause
//                        (01 mem timeout, 10 FPU timeout, 11 undefined Op)
//   StateOut[3:0]        current state encoding, for debug
// -----------------------------------------------------------------------------
module mainfsm_ws #(
  parameter bit FPU_EN   = 1'b1,
  parameter int WAIT_MAX = 8,
  parameter int WAIT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  input  logic       FPUDone,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       MemReq,
  output logic       FPUStart,
  output logic       FPUW,
  output logic       Fault,
  output logic [1:0] FaultCause,
  output logic [3:0] StateOut
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_FPUEX  = 4'd10,
    S_FPUWB  = 4'd11,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_MEMTO = 2'b01;
  localparam logic [1:0] CAUSE_FPUTO = 2'b10;
  localparam logic [1:0] CAUSE_UNDEF = 2'b11;

  // Counter value seen in the last permitted wait cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (WAIT_MAX > 0) ? WAIT_W'(WAIT_MAX - 1) : '0;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              is_wait;
  logic              ready;
  logic              timeout;
  logic [1:0]        cause_next;
  logic              fault_q;
  logic [1:0]        cause_q;

  // Only Funct[5] and Funct[0] steer this FSM; the rest belongs to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // Which states wait, and which handshake releases them.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    is_wait = 1'b0;
    ready   = 1'b0;
    unique case (state)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        is_wait = 1'b1;
        ready   = MemReady;
      end
      S_FPUEX: begin
        is_wait = 1'b1;
        ready   = FPUDone;
      end
      default: ;
    endcase
  end

  // Ready in the last permitted cycle wins over the timeout.
  assign timeout = (WAIT_MAX > 0) && is_wait && !ready && (wait_cnt == WAIT_LAST);

  // Next-state logic.
  always_comb begin
    state_next = state;
    cause_next = CAUSE_NONE;
    unique case (state)
      S_FETCH:  if (MemReady) state_next = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          2'b00: state_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01: state_next = S_MEMADR;
          2'b10: state_next = S_BRANCH;
          2'b11: begin
            if (FPU_EN) begin
              state_next = S_FPUEX;
            end else begin
              state_next = S_FAULT;
              cause_next = CAUSE_UNDEF;
            end
          end
          default: ;
        endcase
      end
      S_EXECR:  state_next = S_ALUWB;
      S_EXECI:  state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_MEMADR: state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_next = S_MEMWB;
      S_MEMWR:  if (MemReady) state_next = S_FETCH;
      S_MEMWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_FPUEX:  if (FPUDone) state_next = S_FPUWB;
      S_FPUWB:  state_next = S_FETCH;
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_FETCH;
    endcase

    if (timeout) begin
      state_next = S_FAULT;
      cause_next = (state == S_FPUEX) ? CAUSE_FPUTO : CAUSE_MEMTO;
    end
  end

  // The counter restarts on every state change, so it also tells FPUEX
  // whether this is the first cycle of the visit.
  always_comb begin
    if (state_next != state)
      wait_cnt_next = '0;
    else if (is_wait && !ready)
      wait_cnt_next = wait_cnt + 1'b1;
    else
      wait_cnt_next = wait_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      // Sticky: captured once on entry to FAULT, cleared only by reset.
      if (state_next == S_FAULT && state != S_FAULT) begin
        fault_q <= 1'b1;
        cause_q <= cause_next;
      end
    end
  end

  // Outputs: decoded from state; IRWrite, NextPC and MemW also follow MemReady.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    MemReq    = 1'b0;
    FPUStart  = 1'b0;
    FPUW      = 1'b0;
    unique case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_EXECR: ALUOp = 1'b1;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      S_ALUWB:  RegW    = 1'b1;
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWR: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        MemW   = MemReady;
      end
      S_MEMWB: begin
        RegW      = 1'b1;
        ResultSrc = 2'b01;
      end
      S_BRANCH: begin
        Branch    = 1'b1;
        ResultSrc = 2'b10;
        ALUSrcB   = 2'b01;
      end
      S_FPUEX:  FPUStart = (wait_cnt == '0);
      S_FPUWB:  FPUW     = 1'b1;
      default: ;
    endcase
  end

  assign Fault      = fault_q;
  assign FaultCause = cause_q;
  assign StateOut   = state;

endmodule

// File: tb/tb_mainfsm_ws.sv
// -----------------------------------------------------------------------------
// tb_mainfsm_ws
//
// Directed bench for mainfsm_ws. Instance "dut" uses the defaults
// (FPU_EN=1, WAIT_MAX=8); instance "dut_b" uses FPU_EN=0, WAIT_MAX=4.
// Inputs are shared; each instance has its own reset so only one runs at a
// time. Inputs change 1 time unit after a rising edge, outputs are sampled
// 3 time units after it.
// -----------------------------------------------------------------------------
module tb_mainfsm_ws;

  // Control vector packing:
  // {IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
  //  ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], MemReq, FPUStart, FPUW}
  localparam logic [15:0] C_FETCH_NR = 16'h00D4;
  localparam logic [15:0] C_FETCH_R  = 16'hA0D4;
  localparam logic [15:0] C_DECODE   = 16'h00D0;
  localparam logic [15:0] C_EXECR    = 16'h0200;
  localparam logic [15:0] C_EXECI    = 16'h0220;
  localparam logic [15:0] C_ALUWB    = 16'h1000;
  localparam logic [15:0] C_MEMADR   = 16'h0020;
  localparam logic [15:0] C_MEMRD    = 16'h4004;
  localparam logic [15:0] C_MEMWR_NR = 16'h4004;
  localparam logic [15:0] C_MEMWR_R  = 16'h4804;
  localparam logic [15:0] C_MEMWB    = 16'h1008;
  localparam logic [15:0] C_BRANCH   = 16'h0430;
  localparam logic [15:0] C_FPUEX_S  = 16'h0002;
  localparam logic [15:0] C_FPUEX    = 16'h0000;
  localparam logic [15:0] C_FPUWB    = 16'h0001;
  localparam logic [15:0] C_FAULT    = 16'h0000;

  logic       clk;
  logic       reset, reset_b;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady, FPUDone;

  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic       MemReq, FPUStart, FPUW, Fault;
  logic [1:0] FaultCause;
  logic [3:0] StateOut;

  logic       IRWrite_b, AdrSrc_b, NextPC_b, RegW_b, MemW_b, Branch_b, ALUOp_b;
  logic [1:0] ALUSrcA_b, ALUSrcB_b, ResultSrc_b;
  logic       MemReq_b, FPUStart_b, FPUW_b, Fault_b;
  logic [1:0] FaultCause_b;
  logic [3:0] StateOut_b;

  logic [15:0] ctl, ctl_b;
  assign ctl   = {IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
                  ALUSrcA, ALUSrcB, ResultSrc, MemReq, FPUStart, FPUW};
  assign ctl_b = {IRWrite_b, AdrSrc_b, NextPC_b, RegW_b, MemW_b, Branch_b, ALUOp_b,
                  ALUSrcA_b, ALUSrcB_b, ResultSrc_b, MemReq_b, FPUStart_b, FPUW_b};

  int n_checks = 0;
  int n_errors = 0;

  mainfsm_ws dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .MemReady(MemReady), .FPUDone(FPUDone),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .MemReq(MemReq), .FPUStart(FPUStart), .FPUW(FPUW),
    .Fault(Fault), .FaultCause(FaultCause), .StateOut(StateOut)
  );

  mainfsm_ws #(.FPU_EN(1'b0), .WAIT_MAX(4), .WAIT_W(4)) dut_b (
    .clk(clk), .reset(reset_b), .Op(Op), .Funct(Funct),
    .MemReady(MemReady), .FPUDone(FPUDone),
    .IRWrite(IRWrite_b), .AdrSrc(AdrSrc_b), .NextPC(NextPC_b), .RegW(RegW_b),
    .MemW(MemW_b), .Branch(Branch_b), .ALUOp(ALUOp_b),
    .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ResultSrc(ResultSrc_b),
    .MemReq(MemReq_b), .FPUStart(FPUStart_b), .FPUW(FPUW_b),
    .Fault(Fault_b), .FaultCause(FaultCause_b), .StateOut(StateOut_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check dut state and controls for the current cycle, then advance a cycle.
  task automatic cyc(input logic [3:0] es, input logic [15:0] ec, input string tag);
    #2;
    check({tag, " state"}, 32'(StateOut), 32'(es));
    check({tag, " ctl"},   32'(ctl),      32'(ec));
    @(posedge clk); #1;
  endtask

  task automatic cyc_b(input logic [3:0] es, input string tag);
    #2;
    check({tag, " state"}, 32'(StateOut_b), 32'(es));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; reset_b = 1'b1;
    Op = 2'b00; Funct = 6'b000000; MemReady = 1'b0; FPUDone = 1'b0;

    // Reset state: FETCH outputs, no fault.
    #2;
    check("rst state", 32'(StateOut), 32'd0);
    check("rst ctl",   32'(ctl),      32'(C_FETCH_NR));
    check("rst fault", 32'({Fault, FaultCause}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    MemReady = 1'b1;

    // Data-processing, register operand: 0,1,6,8,0.
    cyc(4'd0, C_FETCH_R, "dpr fetch");
    cyc(4'd1, C_DECODE,  "dpr decode");
    cyc(4'd6, C_EXECR,   "dpr execr");
    cyc(4'd8, C_ALUWB,   "dpr aluwb");

    // Data-processing, immediate: 0,1,7,8,0.
    Funct = 6'b100000;
    cyc(4'd0, C_FETCH_R, "dpi fetch");
    cyc(4'd1, C_DECODE,  "dpi decode");
    cyc(4'd7, C_EXECI,   "dpi execi");
    cyc(4'd8, C_ALUWB,   "dpi aluwb");

    // Load with two memory wait cycles.
    Op = 2'b01; Funct = 6'b000001;
    cyc(4'd0, C_FETCH_R, "ld fetch");
    cyc(4'd1, C_DECODE,  "ld decode");
    cyc(4'd2, C_MEMADR,  "ld memadr");
    MemReady = 1'b0;
    cyc(4'd3, C_MEMRD,   "ld memrd w1");
    cyc(4'd3, C_MEMRD,   "ld memrd w2");
    MemReady = 1'b1;
    cyc(4'd3, C_MEMRD,   "ld memrd rdy");
    cyc(4'd4, C_MEMWB,   "ld memwb");

    // Store with two wait cycles: MemW only in the ready cycle.
    Funct = 6'b000000;
    cyc(4'd0, C_FETCH_R, "st fetch");
    cyc(4'd1, C_DECODE,  "st decode");
    cyc(4'd2, C_MEMADR,  "st memadr");
    MemReady = 1'b0;
    cyc(4'd5, C_MEMWR_NR, "st memwr w1");
    cyc(4'd5, C_MEMWR_NR, "st memwr w2");
    MemReady = 1'b1;
    cyc(4'd5, C_MEMWR_R,  "st memwr rdy");

    // Branch: 0,1,9,0.
    Op = 2'b10;
    cyc(4'd0, C_FETCH_R, "br fetch");
    cyc(4'd1, C_DECODE,  "br decode");
    cyc(4'd9, C_BRANCH,  "br branch");

    // FPU with done after three cycles: FPUStart only in the first FPUEX cycle.
    Op = 2'b11;
    cyc(4'd0,  C_FETCH_R, "fpu fetch");
    cyc(4'd1,  C_DECODE,  "fpu decode");
    cyc(4'd10, C_FPUEX_S, "fpu ex c0");
    cyc(4'd10, C_FPUEX,   "fpu ex c1");
    cyc(4'd10, C_FPUEX,   "fpu ex c2");
    FPUDone = 1'b1;
    cyc(4'd10, C_FPUEX,   "fpu ex done");
    FPUDone = 1'b0;
    cyc(4'd11, C_FPUWB,   "fpu wb");
    check("fpu no fault", 32'({Fault, FaultCause}), 32'd0);

    // FPU timeout at WAIT_MAX=8: eight FPUEX cycles, then FAULT cause 10.
    cyc(4'd0,  C_FETCH_R, "fto fetch");
    cyc(4'd1,  C_DECODE,  "fto decode");
    cyc(4'd10, C_FPUEX_S, "fto ex c0");
    for (int i = 1; i < 8; i++) cyc(4'd10, C_FPUEX, "fto ex");
    check("fto fault", 32'({Fault, FaultCause}), 32'({1'b1, 2'b10}));
    cyc(4'd15, C_FAULT, "fto fault1");
    cyc(4'd15, C_FAULT, "fto fault2");

    // Reset clears the fault; then reset asserted mid-FPUEX.
    reset = 1'b1;
    #1;
    check("rst2 fault", 32'({Fault, FaultCause}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(4'd0,  C_FETCH_R, "rmid fetch");
    cyc(4'd1,  C_DECODE,  "rmid decode");
    cyc(4'd10, C_FPUEX_S, "rmid ex c0");
    #2;
    check("rmid ex c1 state", 32'(StateOut), 32'd10);
    MemReady = 1'b0;
    FPUDone  = 1'b1;
    reset    = 1'b1;
    #1;
    check("rmid async state", 32'(StateOut), 32'd0);
    check("rmid async ctl",   32'(ctl),      32'(C_FETCH_NR));
    @(posedge clk); #3;
    check("rmid held state", 32'(StateOut), 32'd0);
    check("rmid no fpuw",    32'(FPUW),     32'd0);
    check("rmid fault",      32'({Fault, FaultCause}), 32'd0);
    FPUDone = 1'b0;

    // Second instance: fetch timeout at WAIT_MAX=4.
    @(posedge clk); #1;
    Op = 2'b00; MemReady = 1'b0;
    reset_b = 1'b0;
    for (int i = 0; i < 4; i++) cyc_b(4'd0, "b to fetch");
    #2;
    check("b to state", 32'(StateOut_b), 32'd15);
    check("b to fault", 32'({Fault_b, FaultCause_b}), 32'({1'b1, 2'b01}));
    check("b to ctl",   32'(ctl_b),      32'(C_FAULT));
    reset_b = 1'b1;
    #1;
    check("b rst fault", 32'({Fault_b, FaultCause_b}), 32'd0);
    @(posedge clk); #1;
    reset_b = 1'b0;

    // Ready in the fourth FETCH cycle wins over the timeout.
    for (int i = 0; i < 3; i++) cyc_b(4'd0, "b late fetch");
    MemReady = 1'b1;
    cyc_b(4'd0, "b late rdy");
    check("b late nofault", 32'({Fault_b, FaultCause_b}), 32'd0);

    // FPU_EN=0: Op=11 in DECODE faults as undefined.
    Op = 2'b11;
    cyc_b(4'd1, "b undef decode");
    #2;
    check("b undef state", 32'(StateOut_b), 32'd15);
    check("b undef fault", 32'({Fault_b, FaultCause_b}), 32'({1'b1, 2'b11}));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mainfsm_ws.md
# mainfsm_ws

Parametrised multicycle main control FSM for the ARM-subset datapath. It sequences fetch, decode, execute, memory and writeback, and drives the datapath mux selects and write enables. It adds two things:
- Memory wait-state handshake with a timeout counter.
- Optional FPU execute path with a start/done handshake, plus sticky fault reporting.

It sits in the controller beside the ALU decoder and condition logic, in place of the fixed-latency main FSM.

## Interface
- FPU_EN, default 1: 1 means Op=11 dispatches to the FPU path; 0 means Op=11 faults as undefined.
- WAIT_MAX, default 8: maximum cycles any wait state may last. 0 disables the timeout.
- WAIT_W, default 4: width of the wait counter. Must satisfy 2^WAIT_W > WAIT_MAX.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- Op  in  2  instruction class: 00 data-proc, 01 memory, 10 branch, 11 FPU
- Funct  in  6  Funct[5] selects immediate operand; Funct[0] selects load (1) or store (0)
- MemReady  in  1  memory completes the current access this cycle
- FPUDone  in  1  FPU result is valid this cycle
- IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp  out  1 each  datapath controls
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects
- MemReq  out  1  memory access request
- FPUStart  out  1  single-cycle FPU launch pulse
- FPUW  out  1  FPU register write enable
- Fault  out  1  sticky fault flag
- FaultCause  out  2  00 none, 01 memory timeout, 10 FPU timeout, 11 undefined Op
- StateOut  out  4  current state encoding, for debug

## Operation
State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, FPUEX=10, FPUWB=11, FAULT=15.

Outputs per state. Any output not listed is 0.
- FETCH: MemReq=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=MemReady.
  - Exits to DECODE when MemReady=1; otherwise holds.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state by Op:
  - 00 → EXECI if Funct[5]=1, else EXECR.
  - 01 → MEMADR.
  - 10 → BRANCH.
  - 11 → FPUEX if FPU_EN=1, else FAULT with cause 11.
- EXECR: ALUOp=1 → ALUWB.
- EXECI: ALUSrcB=01, ALUOp=1 → ALUWB.
- ALUWB: RegW=1 → FETCH.
- MEMADR: ALUSrcB=01 → MEMRD if Funct[0]=1, else MEMWR.
- MEMRD: MemReq=1, AdrSrc=1 → MEMWB when MemReady=1; otherwise holds.
- MEMWR: MemReq=1, AdrSrc=1. MemW=MemReady → FETCH when MemReady=1; otherwise holds.
- MEMWB: RegW=1, ResultSrc=01 → FETCH.
- BRANCH: Branch=1, ResultSrc=10, ALUSrcB=01 → FETCH.
- FPUEX: FPUStart=1 only in the first cycle of the visit (wait counter = 0) → FPUWB when FPUDone=1; otherwise holds.
- FPUWB: FPUW=1 → FETCH.
- FAULT: all controls 0. Holds until reset.

Wait counter and timeout:
- Wait states are FETCH, MEMRD, MEMWR and FPUEX.
- The wait counter clears on every state change. It increments each cycle spent in a wait state without the state's ready signal.
- With WAIT_MAX>0: if the ready signal is low and the counter equals WAIT_MAX−1, the next state is FAULT.
  - FETCH, MEMRD, MEMWR timeouts set cause 01; FPUEX sets cause 10.
- Ready asserted in the same cycle as the timeout: ready wins and the transition proceeds normally.

Fault behaviour:
- Fault and FaultCause are registered and take effect on entry to FAULT.
- Both are cleared only by reset.

## Timing
- Reset: asynchronous entry to FETCH; wait counter=0, Fault=0, FaultCause=00. While in reset, outputs show the FETCH values: MemReq=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, all others 0.
- Reset asserted mid-instruction aborts the instruction immediately; no write enables assert after reset is asserted.
- All outputs are combinational from state. The only exceptions are IRWrite, NextPC and MemW, which are also gated by MemReady in the same cycle.
- Latencies from FETCH entry with zero wait states (MemReady=1 every cycle), in cycles:
  - Data-processing: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - FPU: 4 plus FPU latency. FPUDone sampled in the FPUEX entry cycle counts as 0 FPU latency.
- Each memory wait cycle adds 1 cycle. A wait state lasts at most WAIT_MAX cycles before the FAULT transition.
- FPUStart is exactly one cycle per FPUEX visit, even if FPUDone stays low for several cycles.

## Test plan
- Data-processing, register operand: Op=00, Funct=000000, MemReady=1 → states 0,1,6,8,0; RegW=1 only in state 8; ALUOp=1 only in state 6.
- Load with 2 wait cycles: Op=01, Funct[0]=1, MemReady low for the first 2 cycles of MEMRD → MEMRD lasts 3 cycles, then MEMWB with RegW=1, ResultSrc=01.
- Store: MemW pulses exactly in the single cycle where MemReady=1 inside MEMWR; MemW stays 0 on the preceding wait cycles.
- Timeout with WAIT_MAX=4: MemReady held 0 in FETCH → FAULT entered after 4 FETCH cycles with Fault=1, FaultCause=01. Repeat with MemReady=1 in the 4th cycle → DECODE, no fault.
- FPU path, FPU_EN=1: Op=11, FPUDone after 3 cycles → FPUStart high only in the first FPUEX cycle, FPUW=1 in FPUWB. With FPU_EN=0 → DECODE goes to FAULT with FaultCause=11.
- Reset mid-FPUEX: assert reset asynchronously → state 0 immediately; no FPUW; Fault cleared.
